// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 VGA raster timing with registered pin stage
//
// Purpose: divides clk down to a pixel strobe, walks the hCount/vCount raster,
// flags the visible window, and registers the renderer's colour plus syncs
// onto the VGA pins one pixel behind the counters. Also emits line/frame ticks.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous, active-high reset
//   rgb_in     in   renderer colour for the current (hCount, vCount)
//   hCount     out  current horizontal position
//   vCount     out  current vertical position
//   bright     out  current position lies inside the visible window
//   pix_en     out  one-clk strobe; counters advance on this edge
//   hSync      out  pin-side horizontal sync, active low, one pixel late
//   vSync      out  pin-side vertical sync, active low, one pixel late
//   vga_rgb    out  pin-side colour, one pixel late
//   line_tick  out  one-clk pulse at the start of each line
//   frame_tick out  one-clk pulse at the start of each frame
module vga_timing_gen #(
  parameter int CLK_DIV = 4,
  parameter int H_TOTAL = 800,
  parameter int H_SYNC  = 96,
  parameter int H_START = 144,
  parameter int H_END   = 783,
  parameter int V_TOTAL = 525,
  parameter int V_SYNC  = 2,
  parameter int V_START = 35,
  parameter int V_END   = 514
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] rgb_in,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        bright,
  output logic        pix_en,
  output logic        hSync,
  output logic        vSync,
  output logic [11:0] vga_rgb,
  output logic        line_tick,
  output logic        frame_tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_C  = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_C  = 10'(V_SYNC);
  localparam logic [9:0] H_START_C = 10'(H_START);
  localparam logic [9:0] H_END_C   = 10'(H_END);
  localparam logic [9:0] V_START_C = 10'(V_START);
  localparam logic [9:0] V_END_C   = 10'(V_END);

  logic [DW-1:0] div_q, div_d;
  logic [9:0]    h_q, h_d, v_q, v_d;
  logic          bright_q, bright_d;
  logic          hs_q, hs_d, vs_q, vs_d;
  logic [11:0]   rgb_q, rgb_d;
  logic          line_wrap_q, line_wrap_d, frame_wrap_q, frame_wrap_d;
  logic          line_tick_q, line_tick_d, frame_tick_q, frame_tick_d;
  logic          pix_en_w;

  // Decoded straight from the divider register; with CLK_DIV=1 the register
  // is pinned at zero so the strobe is high even while reset is held.
  assign pix_en_w = (div_q == DIV_LAST);

  always_comb begin
    div_d        = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
    h_d          = h_q;
    v_d          = v_q;
    line_wrap_d  = 1'b0;
    frame_wrap_d = 1'b0;
    if (pix_en_w) begin
      if (h_q == H_LAST) begin
        h_d         = '0;
        line_wrap_d = 1'b1;
        if (v_q == V_LAST) begin
          v_d          = '0;
          frame_wrap_d = 1'b1;
        end else begin
          v_d = v_q + 10'd1;
        end
      end else begin
        h_d = h_q + 10'd1;
      end
    end

    // Window test on the next counts so bright moves on the same edge as them.
    bright_d = bright_q;
    rgb_d    = rgb_q;
    hs_d     = hs_q;
    vs_d     = vs_q;
    if (pix_en_w) begin
      bright_d = (h_d >= H_START_C) && (h_d <= H_END_C) &&
                 (v_d >= V_START_C) && (v_d <= V_END_C);
      // Pin stage samples the pixel that is ending, keeping colour and syncs
      // aligned one pixel behind the counters.
      rgb_d    = bright_q ? rgb_in : 12'h000;
      hs_d     = (h_q >= H_SYNC_C);
      vs_d     = (v_q >= V_SYNC_C);
    end

    // Ticks lag the wrap by one clk: high for the cycle after the count hits 0.
    line_tick_d  = line_wrap_q;
    frame_tick_d = frame_wrap_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q        <= '0;
      h_q          <= '0;
      v_q          <= '0;
      bright_q     <= 1'b0;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      rgb_q        <= '0;
      line_wrap_q  <= 1'b0;
      frame_wrap_q <= 1'b0;
      line_tick_q  <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      h_q          <= h_d;
      v_q          <= v_d;
      bright_q     <= bright_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      rgb_q        <= rgb_d;
      line_wrap_q  <= line_wrap_d;
      frame_wrap_q <= frame_wrap_d;
      line_tick_q  <= line_tick_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign hCount     = h_q;
  assign vCount     = v_q;
  assign bright     = bright_q;
  assign pix_en     = pix_en_w;
  assign hSync      = hs_q;
  assign vSync      = vs_q;
  assign vga_rgb    = rgb_q;
  assign line_tick  = line_tick_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench for vga_timing_gen (default and small raster)
module tb_vga_timing_gen;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic [11:0] rgb_in;

  logic [9:0]  a_h, a_v, b_h, b_v;
  logic        a_bright, a_pix, a_hs, a_vs, a_lt, a_ft;
  logic        b_bright, b_pix, b_hs, b_vs, b_lt, b_ft;
  logic [11:0] a_rgb, b_rgb;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Default 640x480 timing, CLK_DIV=4.
  vga_timing_gen dut_a (
    .clk(clk), .rst(rst_a), .rgb_in(rgb_in),
    .hCount(a_h), .vCount(a_v), .bright(a_bright), .pix_en(a_pix),
    .hSync(a_hs), .vSync(a_vs), .vga_rgb(a_rgb),
    .line_tick(a_lt), .frame_tick(a_ft)
  );

  // Scaled raster (20x12, window h 5..16, v 3..9), CLK_DIV=1: 240-clk frames.
  vga_timing_gen #(
    .CLK_DIV(1), .H_TOTAL(20), .H_SYNC(3), .H_START(5), .H_END(16),
    .V_TOTAL(12), .V_SYNC(2), .V_START(3), .V_END(9)
  ) dut_b (
    .clk(clk), .rst(rst_b), .rgb_in(rgb_in),
    .hCount(b_h), .vCount(b_v), .bright(b_bright), .pix_en(b_pix),
    .hSync(b_hs), .vSync(b_vs), .vga_rgb(b_rgb),
    .line_tick(b_lt), .frame_tick(b_ft)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  function automatic bit win_b(input int h, input int v);
    return (h >= 5) && (h <= 16) && (v >= 3) && (v <= 9);
  endfunction

  initial begin
    int ft_pos[$];
    int lt_cnt, vs_low, rgb_on, pix_low;
    int h, v, pk, ph, pv;

    rst_a  = 1'b1;
    rst_b  = 1'b1;
    rgb_in = 12'hF00;
    tick(3);

    // ---------------- DUT A: reset values ----------------
    chk("a_rst_h", a_h, 0);
    chk("a_rst_v", a_v, 0);
    chk("a_rst_bright", a_bright, 0);
    chk("a_rst_pix_en", a_pix, 0);
    chk("a_rst_hsync", a_hs, 0);
    chk("a_rst_vsync", a_vs, 0);
    chk("a_rst_rgb", a_rgb, 0);
    chk("a_rst_lt", a_lt, 0);
    chk("a_rst_ft", a_ft, 0);

    // Release at a negedge; the next posedge is clk 1.
    rst_a = 1'b0;
    tick(3);
    chk("a_pix_en_clk3", a_pix, 1);
    chk("a_h_clk3", a_h, 0);
    tick(1);
    chk("a_h_clk4", a_h, 1);
    chk("a_pix_en_clk4", a_pix, 0);
    tick(380);
    chk("a_h_clk384", a_h, 96);
    chk("a_hsync_at_96", a_hs, 0);
    tick(4);
    chk("a_h_clk388", a_h, 97);
    chk("a_hsync_at_97", a_hs, 1);
    chk("a_vsync_line0", a_vs, 0);
    chk("a_rgb_blank_line0", a_rgb, 0);
    tick(3200 - 388);
    chk("a_h_clk3200", a_h, 0);
    chk("a_v_clk3200", a_v, 1);
    chk("a_lt_clk3200", a_lt, 0);
    tick(1);
    chk("a_lt_clk3201", a_lt, 1);
    chk("a_ft_clk3201", a_ft, 0);
    tick(1);
    chk("a_lt_clk3202", a_lt, 0);

    // Asynchronous reset mid-line, between clock edges.
    tick(150);
    #2 rst_a = 1'b1;
    #1;
    chk("a_mid_rst_h", a_h, 0);
    chk("a_mid_rst_v", a_v, 0);
    chk("a_mid_rst_hsync", a_hs, 0);
    chk("a_mid_rst_pix_en", a_pix, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    tick(3);
    chk("a_restart_h_clk3", a_h, 0);
    tick(1);
    chk("a_restart_h_clk4", a_h, 1);
    chk("a_restart_v_clk4", a_v, 0);
    chk("a_restart_lt", a_lt, 0);

    // ---------------- DUT B: CLK_DIV=1 scaled raster ----------------
    chk("b_rst_pix_en", b_pix, 1);
    chk("b_rst_h", b_h, 0);
    chk("b_rst_rgb", b_rgb, 0);
    rst_b = 1'b0;
    lt_cnt = 0; vs_low = 0; rgb_on = 0; pix_low = 0;
    for (int k = 1; k <= 725; k++) begin
      tick(1);
      h  = k % 20;          v  = (k / 20) % 12;
      pk = k - 1;
      ph = pk % 20;         pv = (pk / 20) % 12;
      chk("b_h", b_h, h);
      chk("b_v", b_v, v);
      chk("b_bright", b_bright, win_b(h, v));
      chk("b_rgb", b_rgb, win_b(ph, pv) ? 12'hF00 : 12'h000);
      chk("b_hsync", b_hs, (ph >= 3));
      chk("b_vsync", b_vs, (pv >= 2));
      chk("b_lt", b_lt, (pk > 0) && (ph == 0));
      chk("b_ft", b_ft, (pk > 0) && (pk % 240 == 0));
      if (h == 4  && v == 3) chk("b_win_left_out",   b_bright, 0);
      if (h == 5  && v == 3) chk("b_win_left_in",    b_bright, 1);
      if (h == 16 && v == 9) chk("b_win_right_in",   b_bright, 1);
      if (h == 17 && v == 9) chk("b_win_right_out",  b_bright, 0);
      if (h == 5  && v == 2) chk("b_win_top_out",    b_bright, 0);
      if (b_pix !== 1'b1) pix_low++;
      if (b_ft === 1'b1) ft_pos.push_back(k);
      if (k >= 241 && k <= 480) begin
        if (b_lt === 1'b1) lt_cnt++;
        if (b_vs === 1'b0) vs_low++;
        if (b_rgb === 12'hF00) rgb_on++;
      end
    end
    chk("b_pix_en_always", pix_low, 0);
    chk("b_ft_count", ft_pos.size(), 3);
    if (ft_pos.size() == 3) begin
      chk("b_ft_first", ft_pos[0], 241);
      chk("b_ft_spacing1", ft_pos[1] - ft_pos[0], 240);
      chk("b_ft_spacing2", ft_pos[2] - ft_pos[1], 240);
    end
    chk("b_lines_per_frame", lt_cnt, 12);
    chk("b_vsync_low_clks", vs_low, 40);
    chk("b_visible_pixels", rgb_on, 84);

    // Mid-frame reset at (10,7).
    tick(145);
    chk("b_pre_rst_h", b_h, 10);
    chk("b_pre_rst_v", b_v, 7);
    #2 rst_b = 1'b1;
    #1;
    chk("b_mid_rst_h", b_h, 0);
    chk("b_mid_rst_v", b_v, 0);
    chk("b_mid_rst_bright", b_bright, 0);
    chk("b_mid_rst_hsync", b_hs, 0);
    chk("b_mid_rst_vsync", b_vs, 0);
    chk("b_mid_rst_rgb", b_rgb, 0);
    chk("b_mid_rst_lt", b_lt, 0);
    chk("b_mid_rst_ft", b_ft, 0);
    chk("b_mid_rst_pix_en", b_pix, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b0;
    tick(1);
    chk("b_restart_h", b_h, 1);
    chk("b_restart_v", b_v, 0);
    chk("b_restart_lt", b_lt, 0);
    chk("b_restart_ft", b_ft, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480@60 Hz VGA raster timing from the 100 MHz board clock. Produces the current-pixel `hCount`/`vCount`/`bright` that feed the game renderer and its per-pixel `rgb` back to it. Registers that colour onto the VGA pins with matching `hSync`/`vSync`. Provides `frame_tick`/`line_tick` pulses that time game-state updates.

## Interface
- `CLK_DIV`, 4: clk cycles per pixel; must be ≥1.
- `H_TOTAL`, 800: pixels per line.
- `H_SYNC`, 96: hSync low for hCount 0..H_SYNC-1.
- `H_START`, 144: first visible hCount.
- `H_END`, 783: last visible hCount, inclusive.
- `V_TOTAL`, 525: lines per frame.
- `V_SYNC`, 2: vSync low for vCount 0..V_SYNC-1.
- `V_START`, 35: first visible vCount.
- `V_END`, 514: last visible vCount, inclusive.

Ports:
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  asynchronous, active-high reset.
- `rgb_in`  in  12  renderer colour for the current (`hCount`, `vCount`).
- `hCount`  out  10  current horizontal position, 0..H_TOTAL-1.
- `vCount`  out  10  current vertical position, 0..V_TOTAL-1.
- `bright`  out  1  current position is inside the visible window.
- `pix_en`  out  1  one-clk strobe; counters advance on this edge.
- `hSync`  out  1  pin-side horizontal sync, active low, delayed one pixel.
- `vSync`  out  1  pin-side vertical sync, active low, delayed one pixel.
- `vga_rgb`  out  12  pin-side colour, delayed one pixel.
- `line_tick`  out  1  one-clk pulse at the start of each line.
- `frame_tick`  out  1  one-clk pulse at the start of each frame.

## Operation
**Divider**
- `div` counts 0..CLK_DIV-1 and wraps.
- `pix_en = (div == CLK_DIV-1)`, decoded from the register.
- For CLK_DIV=1, `pix_en` is constantly 1 once out of reset.

**Counters** (update only on edges where `pix_en`=1)
- `hCount` increments.
- At H_TOTAL-1 it wraps to 0 and `vCount` increments.
- At vCount V_TOTAL-1 with hCount H_TOTAL-1, both wrap to 0.

**bright**
- Registered.
- Computed from the next-count values so it changes on the same edge as the counts.
- `bright` = H_START≤hCount≤H_END and V_START≤vCount≤V_END.

**Pin stage** (on each `pix_en` edge)
- `vga_rgb` ← `bright` ? `rgb_in` : 0.
- `hSync` ← (hCount ≥ H_SYNC).
- `vSync` ← (vCount ≥ V_SYNC).
- This keeps pin colour and syncs mutually aligned, one pixel behind the counters.

**Ticks**
- `line_tick` is high for the single clk cycle after `hCount` becomes 0.
- `frame_tick` is high for the single clk cycle after (`hCount`, `vCount`) becomes (0,0).
- `frame_tick` implies `line_tick` in the same cycle.

**Reset** (asynchronous; clears all state at once, including mid-line or mid-frame)
- div=0, hCount=0, vCount=0.
- bright=0, hSync=0, vSync=0, vga_rgb=0.
- line_tick=0, frame_tick=0.
- pix_en=0, except 1 when CLK_DIV=1.
- No tick is emitted on reset release. The first frame_tick comes after one full frame.

**Arithmetic**
- All comparisons are unsigned 10-bit.
- Parameters must satisfy H_TOTAL, V_TOTAL ≤ 1024 and H_END < H_TOTAL.

## Timing
- Pixel period = CLK_DIV clks.
- Line = H_TOTAL·CLK_DIV clks = 3200.
- Frame = H_TOTAL·V_TOTAL·CLK_DIV clks = 1,680,000 (59.52 Hz).
- After `rst` falls, the first `pix_en` is at clk cycle CLK_DIV (cycles counted from 1). The counts become (1,0) on that edge.
- Renderer contract: `rgb_in` must be valid combinationally within the same pixel period as `hCount`/`vCount`. It is sampled on the `pix_en` edge that ends that period.
- Pin latency: `rgb_in` → `vga_rgb` is one pixel period.
- `hSync`/`vSync` carry the same one-pixel delay.

## Test plan
- **Reset then free-run, CLK_DIV=4.**
  - `hCount` reaches 1 at clk 4 and 96 at clk 384.
  - Pin `hSync` rises when `hCount`=97.
  - `line_tick` first pulses at clk 3201.
- **Visible window edges.**
  - `bright`=0 at (143,35), 1 at (144,35), 1 at (783,514), 0 at (784,514), 0 at (144,34).
- **Full frame.**
  - `frame_tick` pulses are exactly 1,680,000 clks apart.
  - `vSync` is low for exactly 2·3200 = 6400 clks per frame.
  - 525 `line_tick` pulses occur between consecutive `frame_tick` pulses.
- **Blanking.**
  - Drive `rgb_in`=12'hF00 constantly.
  - `vga_rgb`=12'hF00 only in the pixel after each bright pixel, else 0.
  - 640×480 such pixels per frame.
- **Reset mid-frame.**
  - Assert `rst` at (400,300) for 3 clks.
  - All outputs reach reset values immediately.
  - Counting restarts from (0,0), per the first scenario.
- **CLK_DIV=1.**
  - `pix_en` is constantly 1.
  - Line = 800 clks, frame = 420,000 clks.
